// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, FSM encoding and entry sizing for the RAM request sequencer
package mem_pkg;

  localparam int ADDR_W_DEF  = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int ENTRY_W_DEF = 1 + ADDR_W_DEF + DATA_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Request entry layout is {write, addr, data}
  function automatic int entry_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// rtl/req_fifo.sv - in-order request FIFO with push/pop/full/empty and async active-low reset
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rptr];

  // Storage carries no reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - sequences buffered load/store requests onto a 1-cycle-latency sync RAM
module ram_access_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqData,
  output logic              respValid,
  input  logic              respReady,
  output logic [DATA_W-1:0] respData,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [DATA_W-1:0] ramDataIn,
  output logic              ramWe,
  output logic              ramRd,
  input  logic [DATA_W-1:0] ramDataOut,
  output logic              busy
);

  localparam int ENTRY_W = entry_width(ADDR_W, DATA_W);

  state_t              r_state;
  state_t              w_next;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [ENTRY_W-1:0]  w_head;
  logic                w_head_write;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [DATA_W-1:0]   w_head_data;

  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_din;
  logic                r_ram_we;
  logic                r_ram_rd;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_data;

  req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset_n),
    .i_push  (reqValid && !w_full),
    .i_data  ({reqWrite, reqAddr, reqData}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_write = w_head[ENTRY_W-1];
  assign w_head_addr  = w_head[ENTRY_W-2 -: ADDR_W];
  assign w_head_data  = w_head[DATA_W-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ISSUE remembers the request kind through r_ram_we, which is still high in that cycle
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = ST_ISSUE;
        end
      end
      ST_ISSUE:   w_next = r_ram_we ? ST_IDLE : ST_CAPTURE;
      ST_CAPTURE: w_next = ST_RESP;
      ST_RESP: begin
        if (respReady) begin
          w_next = ST_IDLE;
        end
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ram_addr   <= '0;
      r_ram_din    <= '0;
      r_ram_we     <= 1'b0;
      r_ram_rd     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_ram_we <= 1'b0;
      r_ram_rd <= 1'b0;
      if (w_pop) begin
        r_ram_addr <= w_head_addr;
        r_ram_din  <= w_head_data;
        r_ram_we   <= w_head_write;
        r_ram_rd   <= !w_head_write;
      end
      if (r_state == ST_CAPTURE) begin
        r_resp_data  <= ramDataOut;
        r_resp_valid <= 1'b1;
      end
      if ((r_state == ST_RESP) && respReady) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign reqReady   = !w_full;
  assign ramAddress = r_ram_addr;
  assign ramDataIn  = r_ram_din;
  assign ramWe      = r_ram_we;
  assign ramRd      = r_ram_rd;
  assign respValid  = r_resp_valid;
  assign respData   = r_resp_data;
  assign busy       = !w_empty || (r_state != ST_IDLE);

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Request sequencer directly upstream of the 16x8 synchronous RAM (ports address/dataIn/dataOut/we/rd/clock).
- Accepts load/store requests from the processor datapath over a valid/ready handshake and buffers them in a small in-order FIFO.
- Issues each request to the RAM as a one-cycle rd or we pulse, absorbs the RAM's one-cycle registered read latency, and returns load data over a valid/ready response port with backpressure.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM data width.

Ports:
- clock  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- reqValid  input  1  request present.
- reqReady  output  1  FIFO can accept; equals !full.
- reqWrite  input  1  1 = store, 0 = load.
- reqAddr  input  ADDR_W  request address.
- reqData  input  DATA_W  store data; ignored for loads.
- respValid  output  1  load data available.
- respReady  input  1  consumer accepts response.
- respData  output  DATA_W  load result.
- ramAddress  output  ADDR_W  to RAM address.
- ramDataIn  output  DATA_W  to RAM dataIn.
- ramWe  output  1  to RAM we.
- ramRd  output  1  to RAM rd.
- ramDataOut  input  DATA_W  from RAM dataOut.
- busy  output  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset is asynchronous, active-low (reset_n = 0). It clears the FIFO to empty, sets the FSM to IDLE, and drives ramAddress, ramDataIn, ramWe, ramRd, respValid, respData and busy to 0.
- Reset mid-operation abandons all queued and in-flight requests. ramWe = 0 during reset, so no partial write occurs.
- A request is accepted on a rising edge when reqValid && reqReady. The FIFO stores {write, addr, data}.
- There is no bypass: a push into an empty FIFO is popped on the next edge at the earliest.
- When the FIFO is full, reqReady = 0 even if a pop happens in the same cycle. A simultaneous push and pop at non-full leaves the count unchanged.
- FSM states: IDLE, ISSUE, CAPTURE, RESP. All RAM-side outputs are registered.
- IDLE with FIFO non-empty: on the edge, pop the head, load ramAddress and ramDataIn, and set ramRd = !write, ramWe = write. Go to ISSUE.
- ISSUE lasts one cycle; the RAM acts at the end of it. On the edge, clear ramRd and ramWe. Go to CAPTURE for a load, IDLE for a store.
- CAPTURE: ramDataOut is valid. On the edge, respData <= ramDataOut and respValid <= 1. Go to RESP.
- RESP: hold respData and respValid until respReady = 1. On that edge, clear respValid and go to IDLE. No new issue occurs while RESP is waiting.
- ramRd and ramWe are never both 1. Each is high for exactly one cycle per request.
- ramAddress and ramDataIn hold their last value outside ISSUE.
- Latency from acceptance edge T with the pipe empty:
  - store: RAM updated at edge T+2;
  - load: respValid rises at edge T+3.
- Back-to-back throughput: one store per 2 cycles; one load per 4 cycles when respReady is held at 1.
- Ordering is strictly in-order. A load following a store to the same address returns the stored value.
- Stores produce no response.
- busy is a combinational OR of FIFO non-empty and state != IDLE.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.

Decomposition:
- Shared package mem_pkg holds:
  - ADDR_W and DATA_W defaults;
  - the FSM state encoding (IDLE=0, ISSUE=1, CAPTURE=2, RESP=3);
  - the request entry width constant (1+ADDR_W+DATA_W).
- Sub-module req_fifo: synchronous FIFO with push/pop/full/empty and asynchronous active-low reset, parameterised by DEPTH and entry width.

Test Plan:
- Reset, then load addr 0 with respReady = 1, using the ram model whose power-up image is addr0 = 0xAA, addr1 = 0x0F, addr2 = 0x01, addr3 = 0x02 -> respData = 0xAA, with respValid high exactly at acceptance edge + 3 for one cycle.
- Store 0x5C to addr 7, then load addr 7 on the next cycle -> ramWe one-cycle pulse with ramAddress = 7 and ramDataIn = 0x5C; the load returns 0x5C.
- Hold respReady = 0 and push 6 loads (addrs 0..5) -> reqReady drops after the FIFO is full; RESP holds 0xAA stable. Release respReady -> responses 0xAA, 0x0F, 0x01, 0x02, then the pre-written values for addrs 4 and 5, in order, with none lost.
- Alternate stores/loads to addrs 15 and 0 -> ramRd and ramWe are never simultaneously high; the FIFO pointers wrap correctly over more than 3×DEPTH requests.
- Assert reset_n = 0 during ISSUE of a store to addr 3 -> all outputs go to 0 asynchronously; mem[3] remains 0x02; the FIFO is empty and busy = 0 after release.
- Push a store while the FIFO holds DEPTH-1 entries and a pop occurs in the same cycle -> accepted; the count stays at DEPTH-1.
